lpddr4_refresh_scheduler: RTL
=============================

LPDDR4_REFRESH_SCHEDULER -- requirements
Module: lpddr4_refresh_scheduler

Interface
REQ-001 SHALL have parameter TREFI, 3900, sys_clk cycles per refresh interval.
REQ-002 SHALL have parameter TRP, 18, sys_clk cycles from PREA issue to REFAB permitted.
REQ-003 SHALL have parameter TRFC, 280, sys_clk cycles from REFAB issue to bus release.
REQ-004 SHALL have parameter MAX_POSTPONE, 8, debt at which refresh becomes urgent; debt saturates at 8.
REQ-005 SHALL have port sys_clk input 1: single clock, all logic rising-edge.
REQ-006 SHALL have port sys_rst input 1: reset, synchronous and active-high.
REQ-007 SHALL have port init_done input 1: DRAM initialisation complete; enables interval counting.
REQ-008 SHALL have port sched_idle input 1: main command scheduler has no pending work.
REQ-009 SHALL have port ref_req output 1: request for exclusive DFI command bus ownership.
REQ-010 SHALL have port ref_gnt input 1: bus ownership grant from main scheduler.
REQ-011 SHALL have port cmd_valid output 1: refresh-path command valid toward DFI adapter.
REQ-012 SHALL have port cmd_ready input 1: DFI adapter accepts command this cycle.
REQ-013 SHALL have port cmd_type output 2: 0 NOP, 1 PREA, 2 REFAB.
REQ-014 SHALL have port ref_debt output 4: outstanding refreshes, 0..8.
REQ-015 SHALL have port ref_urgent output 1: ref_debt >= MAX_POSTPONE.
REQ-016 SHALL have port ref_overflow output 1: sticky error, interval tick while debt = 8.

Function
REQ-017 SHALL count interval cycles only while init_done=1; counter held at 0 while init_done=0.
REQ-018 SHALL generate a one-cycle tick when counter = TREFI-1 and wrap counter to 0 that cycle.
REQ-019 SHALL increment ref_debt on tick, decrement on accepted REFAB (cmd_valid & cmd_ready & cmd_type=2); both same cycle -> unchanged.
REQ-020 SHALL saturate ref_debt at 8; tick at 8 without simultaneous decrement sets ref_overflow until reset.
REQ-021 SHALL implement FSM states IDLE, REQ, PREA, WAIT_RP, REFAB, WAIT_RFC.
REQ-022 SHALL go IDLE -> REQ when ref_debt > 0 and (sched_idle or ref_urgent).
REQ-023 SHALL hold ref_req=1 in REQ, PREA, WAIT_RP, REFAB, WAIT_RFC; 0 in IDLE.
REQ-024 SHALL stay in REQ until ref_gnt=1, then go to PREA; ref_gnt sampled only in REQ and at WAIT_RFC exit.
REQ-025 SHALL drive cmd_valid=1, cmd_type=1 in PREA, holding until cmd_ready; acceptance -> WAIT_RP.
REQ-026 SHALL remain in WAIT_RP exactly TRP-1 cycles after PREA acceptance cycle, then go to REFAB (REFAB presented TRP cycles after PREA acceptance).
REQ-027 SHALL drive cmd_valid=1, cmd_type=2 in REFAB, holding until cmd_ready; acceptance -> WAIT_RFC.
REQ-028 SHALL remain in WAIT_RFC TRFC-1 cycles, then go to REFAB if ref_debt > 0 and ref_gnt=1 (back-to-back, no PREA), else IDLE.
REQ-029 SHALL drive cmd_valid=0, cmd_type=0 in all states other than PREA and REFAB.
REQ-030 SHALL keep cmd_type and cmd_valid stable while cmd_valid=1 and cmd_ready=0.
REQ-031 SHALL size the interval counter $clog2(TREFI) bits and the shared timing counter $clog2(max(TRP,TRFC)) bits.

Reset
REQ-032 SHALL on sys_rst=1 force next cycle: FSM IDLE, counters 0, ref_debt 0, ref_overflow 0, ref_req 0, cmd_valid 0, cmd_type 0, ref_urgent 0.
REQ-033 SHALL abandon any in-flight PREA/REFAB on reset mid-operation without issuing further commands.

Structure
REQ-034 SHALL place the cmd_type enum (NOP/PREA/REFAB) and FSM state enum in shared package mc_pkg.
REQ-035 SHALL use one sub-module mc_timer (loadable down-counter with done flag) for TRP/TRFC waits.

Verification (bench parameters TREFI=64, TRP=4, TRFC=20, MAX_POSTPONE=4)
REQ-036 SHALL check init_done=1, sched_idle=1, ref_gnt=1, cmd_ready=1: first tick cycle 63, PREA accepted, REFAB 4 cycles later, ref_req drops 20 cycles after REFAB, ref_debt 1 -> 0.
REQ-037 SHALL check sched_idle=0, ref_gnt=0 for 256 cycles: ref_debt 4, ref_urgent=1, ref_req asserts despite sched_idle=0.
REQ-038 SHALL check debt 3 then grant held: one PREA then three REFABs spaced 20 cycles, no second PREA, ref_debt ends 0.
REQ-039 SHALL check cmd_ready=0 for 5 cycles during PREA: cmd_valid/cmd_type=1 held stable, WAIT_RP starts after acceptance.
REQ-040 SHALL check no grants for 9 intervals: ref_debt stays 8, ref_overflow=1 sticky; sys_rst pulse clears all outputs next cycle.
REQ-041 SHALL check sys_rst asserted in WAIT_RFC: next cycle IDLE, ref_req=0, cmd_valid=0, ref_debt=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types for the LPDDR4 refresh path.
// Command encodings toward the DFI adapter and refresh FSM states.
package mc_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_PREA  = 2'd1,
        CMD_REFAB = 2'd2
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_PREA     = 3'd2,
        ST_WAIT_RP  = 3'd3,
        ST_REFAB    = 3'd4,
        ST_WAIT_RFC = 3'd5
    } ref_state_t;

    localparam int DEBT_MAX = 8;
    localparam int DEBT_W   = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mc_timer.sv
// Loadable down-counter; o_done is high whenever the count sits at zero.
// A load wins over counting in the same cycle.
module mc_timer
    import mc_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/lpddr4_refresh_scheduler.sv
// All-bank refresh scheduler: tracks refresh debt per tREFI interval and
// borrows the DFI command bus to issue PREA + REFAB sequences.
module lpddr4_refresh_scheduler
    import mc_pkg::*;
#(
    parameter int TREFI        = 3900,
    parameter int TRP          = 18,
    parameter int TRFC         = 280,
    parameter int MAX_POSTPONE = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       init_done,
    input  logic       sched_idle,
    output logic       ref_req,
    input  logic       ref_gnt,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_type,
    output logic [3:0] ref_debt,
    output logic       ref_urgent,
    output logic       ref_overflow
);

    localparam int IW   = (TREFI > 1) ? $clog2(TREFI) : 1;
    localparam int TMAX = max_int(TRP, TRFC);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    logic [IW-1:0]     r_icnt;
    logic [DEBT_W-1:0] r_debt;
    logic              r_overflow;
    ref_state_t        r_state;
    logic              r_ref_req;
    logic              r_cmd_valid;
    cmd_t              r_cmd_type;

    logic          w_tick;
    logic          w_dec;
    logic          w_urgent;
    logic          w_load;
    logic [TW-1:0] w_load_val;
    logic          w_done;

    assign w_tick   = init_done && (r_icnt == IW'(TREFI - 1));
    assign w_dec    = r_cmd_valid && cmd_ready && (r_cmd_type == CMD_REFAB);
    assign w_urgent = (r_debt >= DEBT_W'(MAX_POSTPONE));

    always_ff @(posedge sys_clk) begin
        if (sys_rst || !init_done || w_tick) begin
            r_icnt <= '0;
        end else begin
            r_icnt <= r_icnt + 1'b1;
        end
    end

    // Tick and accepted REFAB in the same cycle cancel out.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_debt     <= '0;
            r_overflow <= 1'b0;
        end else if (w_tick && !w_dec) begin
            if (r_debt < DEBT_W'(DEBT_MAX)) begin
                r_debt <= r_debt + 1'b1;
            end else begin
                r_overflow <= 1'b1;
            end
        end else if (w_dec && !w_tick && (r_debt != '0)) begin
            r_debt <= r_debt - 1'b1;
        end
    end

    // Timer loads on command acceptance; assumes TRP and TRFC are >= 2.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        unique case (1'b1)
            (r_state == ST_PREA && cmd_ready): begin
                w_load     = 1'b1;
                w_load_val = TW'(TRP - 2);
            end
            (r_state == ST_REFAB && cmd_ready): begin
                w_load     = 1'b1;
                w_load_val = TW'(TRFC - 2);
            end
            default: begin
                w_load     = 1'b0;
                w_load_val = '0;
            end
        endcase
    end

    mc_timer #(
        .W(TW)
    ) u_timer (
        .i_clk      (sys_clk),
        .i_rst      (sys_rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= ST_IDLE;
            r_ref_req   <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_type  <= CMD_NOP;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if ((r_debt != '0) && (sched_idle || w_urgent)) begin
                        r_state   <= ST_REQ;
                        r_ref_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (ref_gnt) begin
                        r_state     <= ST_PREA;
                        r_cmd_valid <= 1'b1;
                        r_cmd_type  <= CMD_PREA;
                    end
                end
                ST_PREA: begin
                    if (cmd_ready) begin
                        r_state     <= ST_WAIT_RP;
                        r_cmd_valid <= 1'b0;
                        r_cmd_type  <= CMD_NOP;
                    end
                end
                ST_WAIT_RP: begin
                    if (w_done) begin
                        r_state     <= ST_REFAB;
                        r_cmd_valid <= 1'b1;
                        r_cmd_type  <= CMD_REFAB;
                    end
                end
                ST_REFAB: begin
                    if (cmd_ready) begin
                        r_state     <= ST_WAIT_RFC;
                        r_cmd_valid <= 1'b0;
                        r_cmd_type  <= CMD_NOP;
                    end
                end
                ST_WAIT_RFC: begin
                    // Banks are already closed, so further debt skips PREA.
                    if (w_done) begin
                        if ((r_debt != '0) && ref_gnt) begin
                            r_state     <= ST_REFAB;
                            r_cmd_valid <= 1'b1;
                            r_cmd_type  <= CMD_REFAB;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_ref_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_ref_req   <= 1'b0;
                    r_cmd_valid <= 1'b0;
                    r_cmd_type  <= CMD_NOP;
                end
            endcase
        end
    end

    assign ref_req      = r_ref_req;
    assign cmd_valid    = r_cmd_valid;
    assign cmd_type     = r_cmd_type;
    assign ref_debt     = r_debt;
    assign ref_urgent   = w_urgent;
    assign ref_overflow = r_overflow;

endmodule
